// File: rtl/mux_scan_sel_if.sv
// Channel-select bus: source-side controls and data in, registered sample out.
// master drives the selection and consumes the output; slave is the selector.
interface mux_scan_sel_if #(
  parameter int CH    = 8,
  parameter int WIDTH = 1
);
  localparam int SELW = $clog2(CH);

  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [CH-1:0]         en_mask;
  logic [CH*WIDTH-1:0]   din;
  logic                  out_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      dout;
  logic [SELW-1:0]       out_ch;

  modport master (
    output mode, sel, en_mask, din, out_ready,
    input  out_valid, dout, out_ch
  );

  modport slave (
    input  mode, sel, en_mask, din, out_ready,
    output out_valid, dout, out_ch
  );
endinterface

// File: rtl/mux_scan_sel.sv
// CH-to-1 registered channel selector with direct-select and round-robin scan modes,
// and a valid/ready output stage that holds its sample under back-pressure.
module mux_scan_sel #(
  parameter int CH    = 8,
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_sel_if.slave bus
);
  localparam int SELW = $clog2(CH);
  localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  outCh_q, outCh_d;
  logic             outValid_q, outValid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             mode_q;

  logic             load;
  logic             rise;
  logic [SELW-1:0]  start;
  logic [SELW-1:0]  cand;
  logic             found;
  logic [SELW-1:0]  foundIdx;
  logic [WIDTH-1:0] foundData;
  logic             selOk;
  logic             selEn;
  logic [WIDTH-1:0] selData;

  assign load  = !outValid_q || bus.out_ready;
  assign rise  = bus.mode && !mode_q;
  assign start = rise ? '0 : ptr_q;

  // Direct lookup compares sel against every legal index, so sel >= CH simply never hits.
  always_comb begin
    selOk   = 1'b0;
    selEn   = 1'b0;
    selData = '0;
    for (int k = 0; k < CH; k++) begin
      if (bus.sel == SELW'(k)) begin
        selOk   = 1'b1;
        selEn   = bus.en_mask[k];
        selData = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin search from start; the wrap is an explicit compare so odd CH works.
  always_comb begin
    found    = 1'b0;
    foundIdx = '0;
    cand     = start;
    for (int i = 0; i < CH; i++) begin
      if (!found && bus.en_mask[cand]) begin
        found    = 1'b1;
        foundIdx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + SELW'(1);
    end
    foundData = '0;
    for (int k = 0; k < CH; k++) begin
      if (foundIdx == SELW'(k)) begin
        foundData = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Everything holds unless the output stage can accept a new sample.
  always_comb begin
    dout_d     = dout_q;
    outCh_d    = outCh_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (load) begin
      if (bus.mode) begin
        if (found) begin
          dout_d     = foundData;
          outCh_d    = foundIdx;
          outValid_d = 1'b1;
          ptr_d      = (foundIdx == LAST) ? '0 : foundIdx + SELW'(1);
        end else begin
          outValid_d = 1'b0;
          ptr_d      = start;
        end
      end else if (selOk) begin
        dout_d     = selData;
        outCh_d    = bus.sel;
        outValid_d = selEn;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (rise) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      outCh_q    <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
      mode_q     <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
      mode_q     <= bus.mode;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_ch    = outCh_q;
  assign bus.out_valid = outValid_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: an 8-channel and a 6-channel instance share stimulus and are
// tracked by a behavioural model, plus literal expectations for the directed scenarios.
module tb_mux_scan_sel;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [7:0]  mask = 8'h00;
  logic        ready = 1'b1;
  logic [31:0] din = 32'h8765_4321;
  int          errors = 0;
  int          checks = 0;
  bit          checkEn = 1'b0;

  always #5 clk = ~clk;

  mux_scan_sel_if #(.CH(8), .WIDTH(4)) busA ();
  mux_scan_sel_if #(.CH(6), .WIDTH(4)) busB ();

  assign busA.mode      = mode;
  assign busA.sel       = sel;
  assign busA.en_mask   = mask;
  assign busA.din       = din;
  assign busA.out_ready = ready;
  assign busB.mode      = mode;
  assign busB.sel       = sel;
  assign busB.en_mask   = mask[5:0];
  assign busB.din       = din[23:0];
  assign busB.out_ready = ready;

  mux_scan_sel #(.CH(8), .WIDTH(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  mux_scan_sel #(.CH(6), .WIDTH(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  typedef struct {
    int ptr;
    bit modeQ;
    bit valid;
    int dout;
    int outCh;
  } mstate_t;

  mstate_t mA, mB;

  function automatic mstate_t resetState();
    mstate_t s;
    s.ptr = 0; s.modeQ = 1'b0; s.valid = 1'b0; s.dout = 0; s.outCh = 0;
    return s;
  endfunction

  // One clock of the selector expressed as plain search-and-pick over channel numbers.
  function automatic mstate_t step(mstate_t s, int nch, bit m, int sl, logic [7:0] mk,
                                   logic [31:0] d, bit rdy);
    mstate_t n = s;
    bit load = !s.valid || rdy;
    int first;
    bit hit = 1'b0;
    n.modeQ = m;
    first = (m && !s.modeQ) ? 0 : s.ptr;
    if (m && !s.modeQ && !load) n.ptr = 0;
    if (load) begin
      if (m) begin
        n.valid = 1'b0;
        n.ptr = first;
        for (int i = 0; i < nch; i++) begin
          int c = (first + i) % nch;
          if (!hit && mk[c]) begin
            hit = 1'b1;
            n.valid = 1'b1;
            n.outCh = c;
            n.dout = int'((d >> (c * 4)) & 32'hF);
            n.ptr = (c + 1) % nch;
          end
        end
      end else if (sl < nch) begin
        n.outCh = sl;
        n.dout = int'((d >> (sl * 4)) & 32'hF);
        n.valid = mk[sl];
      end else begin
        n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA = resetState();
      mB = resetState();
    end else begin
      mA = step(mA, 8, mode, int'(sel), mask, din, ready);
      mB = step(mB, 6, mode, int'(sel), mask, din, ready);
    end
  end

  task automatic check1(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Every cycle, away from the active edge, both DUTs must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      check1("model.A.valid", int'(busA.out_valid), int'(mA.valid));
      check1("model.A.dout",  int'(busA.dout),      mA.dout);
      check1("model.A.ch",    int'(busA.out_ch),    mA.outCh);
      check1("model.B.valid", int'(busB.out_valid), int'(mB.valid));
      check1("model.B.dout",  int'(busB.dout),      mB.dout);
      check1("model.B.ch",    int'(busB.out_ch),    mB.outCh);
    end
  end

  task automatic applyStimulus(bit m, logic [2:0] s, logic [7:0] mk, bit r);
    mode = m;
    sel = s;
    mask = mk;
    ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string name, bit isB, int v, int d, int c);
    if (isB) begin
      check1({name, ".B.valid"}, int'(busB.out_valid), v);
      check1({name, ".B.dout"},  int'(busB.dout),      d);
      check1({name, ".B.ch"},    int'(busB.out_ch),    c);
    end else begin
      check1({name, ".A.valid"}, int'(busA.out_valid), v);
      check1({name, ".A.dout"},  int'(busA.dout),      d);
      check1({name, ".A.ch"},    int'(busA.out_ch),    c);
    end
  endtask

  initial begin
    int seq [6] = '{0, 2, 5, 7, 0, 2};
    #1 rst_n = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset", 1'b0, 0, 0, 0);
    checkOutput("reset", 1'b1, 0, 0, 0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 3'd5, 8'hFF, 1'b1);
    checkOutput("direct", 1'b0, 1, 6, 5);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'd0, 8'hA5, 1'b1);
      checkOutput("scan", 1'b0, 1, seq[i] + 1, seq[i]);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd0, 8'hA5, 1'b0);
      checkOutput("stall", 1'b0, 1, 3, 2);
    end
    applyStimulus(1'b1, 3'd0, 8'hA5, 1'b1);
    checkOutput("resume", 1'b0, 1, 6, 5);

    applyStimulus(1'b1, 3'd0, 8'h00, 1'b1);
    checkOutput("mask0", 1'b0, 0, 6, 5);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 3'd0, 8'h10, 1'b1);
      checkOutput("single", 1'b0, 1, 5, 4);
    end

    applyStimulus(1'b0, 3'd7, 8'hFF, 1'b1);
    check1("selOOR.B.valid", int'(busB.out_valid), 0);
    checkOutput("sel7", 1'b0, 1, 8, 7);
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("rise", 1'b1, 1, 1, 0);
    checkOutput("rise", 1'b0, 1, 1, 0);

    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("scan2", 1'b0, 1, 2, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("asyncRst", 1'b0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("restart", 1'b0, 1, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      rst_n = 1'b1;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 3'($urandom);
      case ($urandom_range(0, 9))
        0:       mask = 8'h00;
        1, 2:    mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
        default: mask = 8'($urandom);
      endcase
      ready = ($urandom_range(0, 3) != 0);
      din = $urandom;
      @(posedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
